// File: rtl/uart_boot_loader.sv
// uart_boot_loader: bus master that streams a boot image out of the UART
// controller's receive FIFO and writes it to memory.
// Image format, little-endian 32-bit words: load address, word count, payload.
// When the load completes, o_done pulses and o_boot_addr holds the entry point.
module uart_boot_loader #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] UART_BASE  = ADDR_WIDTH'(32'hc000_0000),
   parameter int unsigned           MAX_WORDS  = 65536
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  i_start,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   output logic [ADDR_WIDTH-1:0] o_boot_addr,
   output logic                  o_req,
   output logic                  o_rnw,
   output logic [ADDR_WIDTH-1:0] o_address,
   output logic [DATA_WIDTH-1:0] o_data,
   input  logic                  i_ack,
   input  logic [DATA_WIDTH-1:0] i_data
);

   localparam logic [ADDR_WIDTH-1:0] DR_ADDR  = UART_BASE;
   localparam logic [ADDR_WIDTH-1:0] FSR_ADDR = UART_BASE + ADDR_WIDTH'(8);
   localparam logic [31:0]           MAX_LEN  = 32'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_FSR,
      S_RD_DR,
      S_WR_MEM,
      S_DONE,
      S_ERROR
   } state_t;

   // Index of the word being assembled: load address, length, then payload.
   localparam logic [1:0] W_ADDR    = 2'd0;
   localparam logic [1:0] W_LEN     = 2'd1;
   localparam logic [1:0] W_PAYLOAD = 2'd2;

   state_t                  state_q;
   logic                    req_q;
   logic                    rnw_q;
   logic [ADDR_WIDTH-1:0]   address_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic                    done_q;
   logic                    error_q;
   logic [ADDR_WIDTH-1:0]   boot_addr_q;
   logic [ADDR_WIDTH-1:0]   load_addr_q;
   logic [31:0]             length_q;
   logic [31:0]             payload_cnt_q;
   logic [31:0]             word_q;
   logic [1:0]              byte_cnt_q;
   logic [1:0]              word_idx_q;

   logic [31:0]             word_d;
   logic [ADDR_WIDTH-1:0]   wr_offset;
   logic                    unused_data;

   // Received bytes enter at the top, so the first byte ends up in bits [7:0].
   assign word_d      = {i_data[7:0], word_q[31:8]};
   // Byte offset of the current payload word; wraps modulo the address space.
   assign wr_offset   = ADDR_WIDTH'({payload_cnt_q, 2'b00});
   assign unused_data = ^i_data[DATA_WIDTH-1:8];

   assign o_busy      = (state_q != S_IDLE);
   assign o_done      = done_q;
   assign o_error     = error_q;
   assign o_boot_addr = boot_addr_q;
   assign o_req       = req_q;
   assign o_rnw       = rnw_q;
   assign o_address   = address_q;
   assign o_data      = data_q;

   // Load sequencer: raises a registered request one cycle after entering a
   // bus state, holds it until acked, and leaves the state on the ack edge.
   always_ff @(posedge clk or negedge n_rst) begin
      // NOTE: every register, including the datapath, is cleared by the async
      // reset so an abandoned load leaves nothing behind; state uses <= only.
      if (!n_rst) begin
         state_q       <= S_IDLE;
         req_q         <= 1'b0;
         rnw_q         <= 1'b0;
         address_q     <= '0;
         data_q        <= '0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         boot_addr_q   <= '0;
         load_addr_q   <= '0;
         length_q      <= '0;
         payload_cnt_q <= '0;
         word_q        <= '0;
         byte_cnt_q    <= '0;
         word_idx_q    <= W_ADDR;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  byte_cnt_q    <= '0;
                  word_idx_q    <= W_ADDR;
                  payload_cnt_q <= '0;
                  error_q       <= 1'b0;
                  state_q       <= S_RD_FSR;
               end
            end
            S_RD_FSR: begin
               if (!req_q) begin
                  req_q     <= 1'b1;
                  rnw_q     <= 1'b1;
                  address_q <= FSR_ADDR;
               end else if (i_ack) begin
                  req_q <= 1'b0;
                  // Bit 0 is RXFE: keep polling while the FIFO is empty.
                  if (!i_data[0]) state_q <= S_RD_DR;
               end
            end
            S_RD_DR: begin
               if (!req_q) begin
                  req_q     <= 1'b1;
                  rnw_q     <= 1'b1;
                  address_q <= DR_ADDR;
               end else if (i_ack) begin
                  req_q      <= 1'b0;
                  word_q     <= word_d;
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q != 2'd3) begin
                     state_q <= S_RD_FSR;
                  end else if (word_idx_q == W_ADDR) begin
                     load_addr_q <= ADDR_WIDTH'(word_d);
                     word_idx_q  <= W_LEN;
                     state_q     <= S_RD_FSR;
                  end else if (word_idx_q == W_LEN) begin
                     length_q   <= word_d;
                     word_idx_q <= W_PAYLOAD;
                     if (word_d == 32'd0) begin
                        done_q      <= 1'b1;
                        boot_addr_q <= load_addr_q;
                        state_q     <= S_DONE;
                     end else if (word_d > MAX_LEN) begin
                        state_q <= S_ERROR;
                     end else begin
                        state_q <= S_RD_FSR;
                     end
                  end else begin
                     state_q <= S_WR_MEM;
                  end
               end
            end
            S_WR_MEM: begin
               if (!req_q) begin
                  req_q     <= 1'b1;
                  rnw_q     <= 1'b0;
                  address_q <= load_addr_q + wr_offset;
                  data_q    <= DATA_WIDTH'(word_q);
               end else if (i_ack) begin
                  req_q         <= 1'b0;
                  payload_cnt_q <= payload_cnt_q + 32'd1;
                  if (payload_cnt_q + 32'd1 == length_q) begin
                     done_q      <= 1'b1;
                     boot_addr_q <= load_addr_q;
                     state_q     <= S_DONE;
                  end else begin
                     state_q <= S_RD_FSR;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            S_ERROR: begin
               error_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: drives boot images through a behavioural UART/memory
// bus model and compares each load against an image-level reference model.
module tb_uart_boot_loader;

   localparam int unsigned AW       = 32;
   localparam int unsigned DW       = 32;
   localparam logic [31:0] BASE     = 32'hc000_0000;
   localparam logic [31:0] FSR      = BASE + 32'd8;
   localparam int unsigned MAXW     = 4;

   logic          clk;
   logic          n_rst;
   logic          i_start;
   logic          o_busy;
   logic          o_done;
   logic          o_error;
   logic [AW-1:0] o_boot_addr;
   logic          o_req;
   logic          o_rnw;
   logic [AW-1:0] o_address;
   logic [DW-1:0] o_data;
   logic          i_ack;
   logic [DW-1:0] i_data;

   int n_assert = 0;
   int n_fail   = 0;

   // Bus model state
   logic [7:0]  rx_q[$];
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          fsr_count;
   int          dr_count;
   int          polls_per_byte;
   int          polls_left;
   int          ack_delay;
   bit          fsr_ready;

   // Reference model of the current image
   logic [31:0] cur_words[$];
   logic [31:0] cur_addr;
   logic [31:0] cur_len;
   bit          exp_err;
   int          exp_writes;
   int          exp_bytes;
   logic [31:0] exp_boot;
   logic [31:0] last_boot;

   uart_boot_loader #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .UART_BASE  (BASE),
      .MAX_WORDS  (MAXW)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .i_start     (i_start),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_error     (o_error),
      .o_boot_addr (o_boot_addr),
      .o_req       (o_req),
      .o_rnw       (o_rnw),
      .o_address   (o_address),
      .o_data      (o_data),
      .i_ack       (i_ack),
      .i_data      (i_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin : watchdog
      #(10 * 80000);
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "time limit");
   end

   // Answers one acked transaction: FSR/DR reads from the byte stream, writes logged.
   task automatic serve();
      logic [31:0] r;
      r = $urandom();
      if (o_rnw === 1'b1 && o_address === FSR) begin
         fsr_count++;
         if (polls_left > 0 || rx_q.size() == 0) begin
            if (polls_left > 0) polls_left--;
            i_data    = r | 32'd1;
            fsr_ready = 1'b0;
         end else begin
            i_data    = r & ~32'd1;
            fsr_ready = 1'b1;
         end
      end else if (o_rnw === 1'b1 && o_address === BASE) begin
         dr_count++;
         n_assert++;
         if (!fsr_ready || rx_q.size() == 0) begin
            n_fail++;
            $display("FAIL dr_order: DR read with fifo_ready=%0b queued=%0d, required fifo_ready=1 and data queued",
                     fsr_ready, rx_q.size());
            i_data = r;
         end else begin
            i_data = {r[31:8], rx_q.pop_front()};
         end
         fsr_ready  = 1'b0;
         polls_left = polls_per_byte;
      end else if (o_rnw === 1'b0) begin
         wr_addr_q.push_back(o_address);
         wr_data_q.push_back(o_data);
      end else begin
         n_assert++;
         n_fail++;
         $display("FAIL read_addr: read from %h, required %h or %h", o_address, BASE, FSR);
         i_data = r;
      end
   endtask

   // Bus slave: acks after ack_delay wait cycles and checks request stability.
   initial begin : bus_model
      int          wait_cnt;
      bit          in_txn;
      logic [31:0] cap_addr;
      logic [31:0] cap_data;
      logic        cap_rnw;
      i_ack    = 1'b0;
      i_data   = '0;
      in_txn   = 1'b0;
      wait_cnt = 0;
      cap_addr = '0;
      cap_data = '0;
      cap_rnw  = 1'b0;
      forever begin
         @(negedge clk);
         i_ack = 1'b0;
         if (o_req !== 1'b1) begin
            in_txn = 1'b0;
         end else begin
            if (!in_txn) begin
               in_txn   = 1'b1;
               wait_cnt = 0;
               cap_addr = o_address;
               cap_rnw  = o_rnw;
               cap_data = o_data;
            end else begin
               n_assert++;
               if (o_address !== cap_addr || o_rnw !== cap_rnw || o_data !== cap_data) begin
                  n_fail++;
                  $display("FAIL req_stable: addr %h rnw %b data %h, required addr %h rnw %b data %h",
                           o_address, o_rnw, o_data, cap_addr, cap_rnw, cap_data);
               end
            end
            if (wait_cnt >= ack_delay) begin
               serve();
               i_ack  = 1'b1;
               in_txn = 1'b0;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   task automatic push_word(input logic [31:0] w);
      for (int b = 0; b < 4; b++) rx_q.push_back(w[8*b +: 8]);
   endtask

   task automatic fill_random_words(input int n);
      cur_words.delete();
      for (int i = 0; i < n; i++) cur_words.push_back($urandom());
   endtask

   // Builds the byte stream for an image and derives the expected outcome.
   task automatic prepare(input logic [31:0] addr, input logic [31:0] len,
                          input int polls, input int delay);
      rx_q.delete();
      wr_addr_q.delete();
      wr_data_q.delete();
      fsr_count      = 0;
      dr_count       = 0;
      fsr_ready      = 1'b0;
      polls_per_byte = polls;
      polls_left     = polls;
      ack_delay      = delay;
      cur_addr       = addr;
      cur_len        = len;
      exp_err        = (len > MAXW);
      exp_writes     = exp_err ? 0 : int'(len);
      exp_bytes      = 8 + 4 * exp_writes;
      exp_boot       = exp_err ? last_boot : addr;
      push_word(addr);
      push_word(len);
      for (int i = 0; i < exp_writes; i++) push_word(cur_words[i]);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      n_assert++;
      if (o_busy !== 1'b1 || o_error !== 1'b0) begin
         n_fail++;
         $display("FAIL start_accept: busy %b error %b, required busy 1 error 0", o_busy, o_error);
      end
   endtask

   // Waits for the load to end (optionally re-pulsing i_start mid-load) and checks it.
   task automatic finish_load(input int poke_at);
      int budget;
      int done_cnt;
      bit done_prev;
      bit done_before_idle;
      bit timed_out;
      budget           = 100 + (exp_bytes * (polls_per_byte + 2) + exp_writes) * (ack_delay + 2);
      done_cnt         = 0;
      done_prev        = 1'b0;
      done_before_idle = 1'b0;
      timed_out        = 1'b1;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(negedge clk);
         i_start = (cyc == poke_at);
         if (o_busy !== 1'b1) begin
            timed_out        = 1'b0;
            done_before_idle = done_prev;
            break;
         end
         if (o_done === 1'b1) done_cnt++;
         done_prev = (o_done === 1'b1);
      end
      i_start = 1'b0;

      n_assert++;
      if (timed_out) begin
         n_fail++;
         $display("FAIL load_timeout: still busy after %0d cycles, required idle", budget);
      end
      n_assert++;
      if (done_cnt != (exp_err ? 0 : 1) || done_before_idle != !exp_err) begin
         n_fail++;
         $display("FAIL done_pulse: %0d pulses (last busy cycle %0b), required %0d (%0b)",
                  done_cnt, done_before_idle, exp_err ? 0 : 1, !exp_err);
      end
      n_assert++;
      if (o_error !== exp_err) begin
         n_fail++;
         $display("FAIL error_flag: got %b, required %b", o_error, exp_err);
      end
      n_assert++;
      if (o_boot_addr !== exp_boot) begin
         n_fail++;
         $display("FAIL boot_addr: got %h, required %h", o_boot_addr, exp_boot);
      end
      n_assert++;
      if (wr_addr_q.size() != exp_writes) begin
         n_fail++;
         $display("FAIL write_count: got %0d, required %0d", wr_addr_q.size(), exp_writes);
      end
      for (int i = 0; i < exp_writes && i < wr_addr_q.size(); i++) begin
         logic [31:0] ea;
         ea = cur_addr + 32'(4 * i);
         n_assert++;
         if (wr_addr_q[i] !== ea || wr_data_q[i] !== cur_words[i]) begin
            n_fail++;
            $display("FAIL write_%0d: got %h -> %h, required %h -> %h",
                     i, wr_data_q[i], wr_addr_q[i], cur_words[i], ea);
         end
      end
      n_assert++;
      if (fsr_count != exp_bytes * (polls_per_byte + 1) || dr_count != exp_bytes) begin
         n_fail++;
         $display("FAIL read_count: fsr %0d dr %0d, required fsr %0d dr %0d",
                  fsr_count, dr_count, exp_bytes * (polls_per_byte + 1), exp_bytes);
      end
      n_assert++;
      if (rx_q.size() != 0 || o_req !== 1'b0) begin
         n_fail++;
         $display("FAIL load_end: bytes left %0d req %b, required 0 and 0", rx_q.size(), o_req);
      end
      last_boot = exp_boot;
   endtask

   task automatic run_load(input logic [31:0] addr, input logic [31:0] len,
                           input int polls, input int delay, input int poke_at);
      prepare(addr, len, polls, delay);
      pulse_start();
      finish_load(poke_at);
   endtask

   task automatic check_all_zero(input string name);
      n_assert++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_error !== 1'b0 || o_boot_addr !== '0 ||
          o_req !== 1'b0 || o_rnw !== 1'b0 || o_address !== '0 || o_data !== '0) begin
         n_fail++;
         $display("FAIL %s: busy %b done %b err %b boot %h req %b rnw %b addr %h data %h, required all 0",
                  name, o_busy, o_done, o_error, o_boot_addr, o_req, o_rnw, o_address, o_data);
      end
   endtask

   task automatic test_reset();
      n_rst   = 1'b0;
      i_start = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset_held");
      n_rst = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("reset_released");
   endtask

   task automatic test_nominal();
      cur_words.delete();
      cur_words.push_back(32'hDEAD_BEEF);
      cur_words.push_back(32'h0123_4567);
      run_load(32'h0000_1000, 32'd2, 0, 0, 0);
   endtask

   task automatic test_fifo_polling();
      fill_random_words(3);
      run_load(32'h0000_4000, 32'd3, 5, 0, 0);
   endtask

   task automatic test_zero_length();
      fill_random_words(0);
      run_load(32'h0000_8000, 32'd0, 0, 0, 0);
   endtask

   task automatic test_length_error();
      fill_random_words(0);
      run_load(32'h0000_2000, 32'd5, 0, 0, 0);
      repeat (4) @(negedge clk);
      n_assert++;
      if (o_error !== 1'b1 || o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL error_sticky: error %b busy %b, required 1 0", o_error, o_busy);
      end
      fill_random_words(1);
      run_load(32'h0000_2400, 32'd1, 0, 0, 0);
   endtask

   task automatic test_ack_stall_wrap();
      fill_random_words(2);
      run_load(32'hFFFF_FFFC, 32'd2, 0, 10, 0);
   endtask

   task automatic test_start_while_busy();
      fill_random_words(2);
      run_load(32'h0000_6000, 32'd2, 0, 1, 25);
   endtask

   task automatic test_reset_mid_write();
      bit found;
      fill_random_words(3);
      prepare(32'h0000_3000, 32'd3, 0, 10);
      pulse_start();
      found = 1'b0;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         @(negedge clk);
         if (o_req === 1'b1 && o_rnw === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      n_assert++;
      if (!found) begin
         n_fail++;
         $display("FAIL reach_write: no write request seen, required one within 5000 cycles");
      end
      #2 n_rst = 1'b0;
      #1 check_all_zero("reset_mid_write");
      repeat (3) @(negedge clk);
      n_rst     = 1'b1;
      last_boot = '0;
      fill_random_words(2);
      run_load(32'h0000_5000, 32'd2, 1, 0, 0);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 6; k++) begin
         logic [31:0] addr;
         logic [31:0] len;
         addr = $urandom();
         len  = 32'($urandom_range(0, 6));
         fill_random_words(len <= MAXW ? int'(len) : 0);
         run_load(addr, len, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0);
      end
   endtask

   initial begin : main
      n_rst          = 1'b0;
      i_start        = 1'b0;
      ack_delay      = 0;
      polls_per_byte = 0;
      polls_left     = 0;
      fsr_ready      = 1'b0;
      fsr_count      = 0;
      dr_count       = 0;
      last_boot      = '0;
      test_reset();
      test_nominal();
      test_fifo_polling();
      test_zero_length();
      test_length_error();
      test_ack_stall_wrap();
      test_start_while_busy();
      test_reset_mid_write();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
